pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, width of the datapath payload (operands, immediates).
REQ-002 The block SHALL have parameter CTRL_W, default 16, width of the control-signal bundle.
REQ-003 The block SHALL have parameter BUBBLE_CTRL, default all-zero, control value presented when no valid instruction is held.
REQ-004 The block SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-005 Ports SHALL be: clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 in_valid  in  1  upstream stage offers an instruction.
REQ-008 in_ready  out  1  stage can accept; registered output.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-011 flush  in  1  discard all held and incoming instructions this cycle.
REQ-012 out_valid  out  1  stage presents an instruction.
REQ-013 out_ready  in  1  downstream stage accepts.
REQ-014 out_data  out  DATA_W  payload of held instruction.
REQ-015 out_ctrl  out  CTRL_W  control of held instruction, BUBBLE_CTRL when out_valid=0.
REQ-016 stat_flush  out  CNT_W  saturating count of flush cycles.
REQ-017 stat_stall  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Storage SHALL be one main register (drives outputs) and one skid register; state is EMPTY, ONE or FULL.
REQ-019 Accept SHALL occur when in_valid=1 and in_ready=1; drain SHALL occur when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, never combinationally dependent on out_ready.
REQ-021 out_valid SHALL be 1 exactly in ONE and FULL; out_data/out_ctrl SHALL come from the main register with no combinational path from in_*.
REQ-022 EMPTY: accept -> ONE, main <= input; otherwise hold.
REQ-023 ONE: accept and drain -> ONE, main <= input; accept only -> FULL, skid <= input; drain only -> EMPTY; neither -> hold.
REQ-024 FULL: drain -> ONE, main <= skid; otherwise hold; no accept possible.
REQ-025 Latency SHALL be one cycle from accept to out_valid when the stage is EMPTY; order SHALL be strictly FIFO, no instruction duplicated or lost absent flush.
REQ-026 flush=1 SHALL force next state EMPTY, discard main, skid and any same-cycle input, and leave in_ready=1 next cycle; a same-cycle drain is still a valid downstream transfer.
REQ-027 Upon entering EMPTY, the main control register SHALL load BUBBLE_CTRL; out_data MAY retain stale payload.
REQ-028 stat_flush SHALL increment on each cycle with flush=1; stat_stall SHALL increment each cycle with out_valid=1 and out_ready=0; both SHALL saturate at 2^CNT_W-1 without wrap.
REQ-029 Input values while in_valid=0 SHALL have no effect on state or outputs.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk: state EMPTY, in_ready=1, out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, stat_flush=0, stat_stall=0, skid cleared.
REQ-031 Reset asserted mid-operation SHALL discard all held instructions; first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Stream: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, in_ready stays 1, stat_stall=0.
REQ-033 Backpressure: out_ready=0, send A then B -> state FULL, in_ready=0, out_data=A; raise out_ready -> A then B delivered in order, in_ready=1 after A drains; stat_stall counts stall cycles exactly.
REQ-034 Flush in FULL with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1, C never appears, stat_flush=1.
REQ-035 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stat_stall=15 and stays 15.
REQ-036 Async reset: assert rst_n=0 between clock edges while FULL -> out_valid=0, in_ready=1, counters 0 before the next edge.
REQ-037 Random: random in_valid/out_ready/flush over 10000 cycles against a 2-entry FIFO model -> identical output sequence, in_ready never 1 while FULL.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// One-deep pipeline stage with a skid register: in_ready is registered so it never
// depends on out_ready in the same cycle, and the skid entry absorbs the one extra beat.
module pipe_stage_skid #(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stat_flush,
    output logic [CNT_W-1:0]  stat_stall
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic                in_ready_q, out_valid_q;
    logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]    stat_flush_q, stat_flush_d, stat_stall_q, stat_stall_d;
    logic                accept, drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (drain) begin
                    state_d     = EMPTY;
                    main_ctrl_d = BUBBLE_CTRL;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: begin
                state_d     = EMPTY;
                main_ctrl_d = BUBBLE_CTRL;
            end
        endcase
        // Flush wins over everything; a drain in the same cycle has already been seen downstream.
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = BUBBLE_CTRL;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end
    end

    always_comb begin
        stat_flush_d = stat_flush_q;
        stat_stall_d = stat_stall_q;
        if (flush && stat_flush_q != CNT_MAX)
            stat_flush_d = stat_flush_q + CNT_ONE;
        if (out_valid_q && !out_ready && stat_stall_q != CNT_MAX)
            stat_stall_d = stat_stall_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= BUBBLE_CTRL;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stat_flush_q <= '0;
            stat_stall_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d != FULL);
            out_valid_q  <= (state_d != EMPTY);
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stat_flush_q <= stat_flush_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = main_data_q;
    assign out_ctrl   = main_ctrl_q;
    assign stat_flush = stat_flush_q;
    assign stat_stall = stat_stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, all compared
// each cycle against a 2-entry FIFO model with saturating counters.
module tb_pipe_stage_skid;

    localparam int               DW   = 16;
    localparam int               CW   = 8;
    localparam int               NW   = 4;
    localparam logic [CW-1:0]    BUB  = 8'hA5;
    localparam int               CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stat_flush, stat_stall;

    int checks = 0;
    int errors = 0;

    // Reference: queue of {ctrl,data}, at most two entries
    logic [CW+DW-1:0] mq[$];
    int m_flush = 0;
    int m_stall = 0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stat_flush(stat_flush), .stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0][DW-1:0]));
            chk("out_ctrl", 32'(out_ctrl), 32'(mq[0][CW+DW-1:DW]));
        end else begin
            chk("out_ctrl_bubble", 32'(out_ctrl), 32'(BUB));
        end
        chk("stat_flush", 32'(stat_flush), 32'(m_flush));
        chk("stat_stall", 32'(stat_stall), 32'(m_stall));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        bit acc, drn;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (mq.size() < 2);
        drn = ordy && (mq.size() > 0);
        if (mq.size() > 0 && !ordy && m_stall < CMAX) m_stall++;
        if (fl && m_flush < CMAX) m_flush++;
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back({c, d});
        if (fl) mq.delete();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'(BUB));
        chk("rst_stat_flush", 32'(stat_flush), 32'd0);
        chk("rst_stat_stall", 32'(stat_stall), 32'd0);
        rst_n = 1'b1;

        // Stream 1..4 with downstream always ready
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, DW'(i), CW'(8'h10 + i), 1'b1, 1'b0);
            chk("stream_data", 32'(out_data), 32'(i));
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("stream_stall", 32'(stat_stall), 32'd0);

        // Backpressure: A then B while blocked
        step(1'b1, 16'hAAAA, 8'h0A, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 8'h0B, 1'b0, 1'b0);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_data", 32'(out_data), 32'hAAAA);
        step(1'b1, 16'hDEAD, 8'h0D, 1'b0, 1'b0);
        chk("bp_stall_cnt", 32'(stat_stall), 32'd2);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_second", 32'(out_data), 32'hBBBB);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while FULL with C offered
        step(1'b1, 16'h1111, 8'h01, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 8'h02, 1'b0, 1'b0);
        step(1'b1, 16'hCCCC, 8'h0C, 1'b0, 1'b1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ctrl", 32'(out_ctrl), 32'(BUB));
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_cnt", 32'(stat_flush), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_no_c", 32'(out_valid), 32'd0);

        // Stall counter saturation
        step(1'b1, 16'h5A5A, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("sat_stall", 32'(stat_stall), 32'd15);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("sat_hold", 32'(stat_stall), 32'd15);

        // Async reset mid-cycle while FULL
        step(1'b1, 16'h7777, 8'h77, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_ctrl", 32'(out_ctrl), 32'(BUB));
        chk("arst_flush", 32'(stat_flush), 32'd0);
        chk("arst_stall", 32'(stat_stall), 32'd0);
        mq.delete();
        m_flush = 0;
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h4242, 8'h42, 1'b1, 1'b0);
        chk("arst_first_accept", 32'(out_data), 32'h4242);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
